apb_ral_apb_master: RTL
=======================

Name: apb_ral_apb_master

Overview:
APB requester that turns a simple valid/ready command stream (address, write flag, write data) into single APB transfers. It returns the read data and error status on a valid/ready response stream. It is the bus-driving end for the team's APB memory/register slaves: RAL adapter sequences and directed tests use it to reach the 0x0000-0x0FFF RAM window and the 0x1000/0x1004 registers. It keeps at most one transfer outstanding and has an optional access timeout.

Parameters:
ADDR_W, 32, width of cmd_addr/paddr
DATA_W, 32, width of wdata/rdata paths
TIMEOUT, 16, maximum ACCESS-phase cycles before abort; 0 disables timeout; legal range 0..65535

Ports:
pclk  in  1  clock for all logic
preset  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address, passed to paddr unmodified
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  captured prdata for reads; 0 for writes and timeouts
rsp_err  out  1  pslverr seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready / wait-state control
pslverr  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, pclk. Reset is synchronous and active-high (preset). Sampled on the pclk rising edge; it overrides all other activity.
- Reset values: state=IDLE; cmd_ready=0 during reset, 1 in the first cycle after reset; rsp_valid=0; rsp_rdata=0; rsp_err=0; rsp_timeout=0; psel=0; penable=0; pwrite=0; paddr=0; pwdata=0; timeout counter=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid: register cmd_addr into paddr and cmd_write into pwrite.
  - Register pwdata as cmd_wdata for writes and 0 for reads.
  - Next state SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle. Clear the timeout counter. Next state ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - If pready=1: rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0. Next state RESP. psel and penable drop in the following cycle.
  - If pready=0 and TIMEOUT≠0: increment the counter. When the counter equals TIMEOUT-1, abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0, next state RESP. ACCESS therefore lasts at most TIMEOUT cycles.
  - pready is sampled only while in ACCESS.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - rsp_rdata, rsp_err and rsp_timeout are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: next state IDLE, rsp_valid=0.
- Hold rules:
  - cmd_ready is 1 only in IDLE, so there is one outstanding transfer and commands are never buffered.
  - paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS. They hold their last values in RESP and IDLE until the next accept.
- Latency (no wait states, rsp_ready=1):
  - Accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, next accept at N+4.
  - Minimum period is 4 cycles per transfer.
- Each pready=0 cycle in ACCESS adds one cycle.
- Reset mid-transfer, in any state: psel and penable drop in the next cycle, the transfer is abandoned and no response is produced.
- Simultaneous events:
  - pready=1 in the cycle the timeout would fire: pready wins and the transfer completes normally.
  - pslverr is ignored when pready=0.
- No alignment check. The low address bits pass through unchanged.

Test Plan:
- Write then read, against the APB memory slave with pready tied to 1: write 0x1000=0x0000_0007, then read 0x1000 -> rsp_rdata=0x0000_0007, rsp_err=0. Check psel/penable timing N+1/N+2 and rsp_valid at N+3.
- RAM window and RO register: write 0x0010=0xDEAD_BEEF, read 0x0010 -> 0xDEAD_BEEF. Write 0x1004=0xFFFF_FFFF, read 0x1004 -> 0x0000_0000.
- Wait states: the slave holds pready=0 for 3 ACCESS cycles on a read of 0x0010 -> penable high for 4 cycles, paddr/pwrite stable throughout, rsp_valid at N+6.
- Error and timeout:
  - pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0.
  - pready stuck at 0 with TIMEOUT=16 -> ACCESS lasts exactly 16 cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - TIMEOUT=0 -> ACCESS never aborts.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_* held, cmd_ready=0, no new psel. After rsp_ready=1 -> IDLE in the next cycle.
- Reset mid-ACCESS: assert preset during a wait-stated write -> psel/penable/rsp_valid=0 in the next cycle, all outputs at reset values. A subsequent command completes normally.

Source files
------------

// File: rtl/apb_ral_apb_master.sv
// APB requester: turns a valid/ready command stream into single APB transfers
// and returns read data / error status on a valid/ready response stream.
// One transfer outstanding at a time; optional ACCESS-phase timeout.
module apb_ral_apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  // Abort happens in the ACCESS cycle where the counter reaches TIMEOUT-1,
  // so ACCESS never exceeds TIMEOUT cycles.
  localparam bit          TmoEn   = (TIMEOUT != 0);
  localparam logic [15:0] TmoLast = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= StIdle;
      tmo_cnt_q <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        tmo_cnt_d = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        // pready has priority over a timeout firing in the same cycle
        if (pready) begin
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          tmo_d   = 1'b0;
          state_d = StResp;
        end else if (TmoEn) begin
          if (tmo_cnt_q == TmoLast) begin
            rdata_d = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = StResp;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; cmd_ready is suppressed while reset is held
  always_comb begin
    cmd_ready = (state_q == StIdle) && !preset;
    psel      = (state_q == StSetup) || (state_q == StAccess);
    penable   = (state_q == StAccess);
    rsp_valid = (state_q == StResp);
  end

  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule
